// File: rtl/conv_postproc.sv
// conv_postproc: PE-array output stage. Forwards partial sums, or adds bias, activates, requantizes
// and queues packed OFM words. Define CONV_POSTPROC_LEAKY_EN for leaky ReLU (default build: ReLU).
module conv_postproc #(
    parameter int Tout       = 4,
    parameter int W_PSUM     = 32,
    parameter int W_DATA     = 8,
    parameter int W_BIAS     = 16,
    parameter int W_SHIFT    = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     c_layer_start,
    input  logic [W_SHIFT-1:0]       cfg_shift,
    input  logic                     cfg_act_en,
    input  logic [Tout*W_BIAS-1:0]   bm_bias_data,
    input  logic                     c_last_cin,
    input  logic                     i_vld,
    input  logic [Tout*W_PSUM-1:0]   i_acc,
    output logic                     o_psum_we,
    output logic [Tout*W_PSUM-1:0]   o_psum_data,
    output logic                     o_ofm_vld,
    output logic [Tout*W_DATA-1:0]   o_ofm_data,
    input  logic                     i_ofm_rdy,
    output logic                     o_almost_full,
    output logic                     o_overflow,
    output logic                     o_busy
);
    localparam int W_SUM = W_PSUM + 1;
    localparam int W_RND = W_PSUM + 2;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 2;
    localparam logic signed [W_RND-1:0] SAT_HI = W_RND'((2 ** (W_DATA - 1)) - 1);
    localparam logic signed [W_RND-1:0] SAT_LO = W_RND'(-(2 ** (W_DATA - 1)));

    logic [W_SHIFT-1:0]     shift_q;
    logic                   act_en_q;
    logic [Tout*W_BIAS-1:0] bias_q;
    logic [W_SHIFT-1:0]     shift_eff;
    logic                   act_eff;
    logic [Tout*W_BIAS-1:0] bias_eff;

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q  <= '0;
            act_en_q <= 1'b0;
            bias_q   <= '0;
        end else if (c_layer_start) begin
            shift_q  <= cfg_shift;
            act_en_q <= cfg_act_en;
            bias_q   <= bm_bias_data;
        end
    end

    // A beat coincident with c_layer_start already sees the new configuration.
    assign shift_eff = c_layer_start ? cfg_shift    : shift_q;
    assign act_eff   = c_layer_start ? cfg_act_en   : act_en_q;
    assign bias_eff  = c_layer_start ? bm_bias_data : bias_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            o_psum_we   <= 1'b0;
            o_psum_data <= '0;
        end else begin
            o_psum_we <= i_vld & ~c_last_cin;
            if (i_vld & ~c_last_cin) begin
                o_psum_data <= i_acc;
            end
        end
    end

    logic                    s1_vld, s2_vld, s3_vld;
    logic                    s1_act;
    logic [W_SHIFT-1:0]      s1_shift, s2_shift;
    logic signed [W_SUM-1:0] s1_sum [Tout];
    logic signed [W_SUM-1:0] s2_val [Tout];
    logic [Tout*W_DATA-1:0]  s3_word;
    logic signed [W_SUM-1:0] s1_nxt [Tout];
    logic signed [W_SUM-1:0] s2_nxt [Tout];
    logic signed [W_RND-1:0] s3_rnd [Tout];
    logic signed [W_RND-1:0] s3_shr [Tout];
    logic [Tout*W_DATA-1:0]  s3_nxt;
    logic [W_RND-1:0]        rnd_bias;

    assign rnd_bias = (s2_shift == '0) ? '0
                    : ({{(W_RND-1){1'b0}}, 1'b1} << (s2_shift - W_SHIFT'(1)));

    always_comb begin
        s3_nxt = '0;
        for (int a = 0; a < Tout; a++) begin
            s1_nxt[a] = W_SUM'($signed(i_acc[a*W_PSUM +: W_PSUM]))
                      + W_SUM'($signed(bias_eff[a*W_BIAS +: W_BIAS]));
            s2_nxt[a] = s1_sum[a];
            if (s1_act && s1_sum[a][W_SUM-1]) begin
`ifdef CONV_POSTPROC_LEAKY_EN
                s2_nxt[a] = s1_sum[a] >>> 3;
`else
                s2_nxt[a] = '0;
`endif
            end
            // Round half up, then arithmetic shift and clamp to the signed byte range.
            s3_rnd[a] = W_RND'(s2_val[a]) + $signed(rnd_bias);
            s3_shr[a] = s3_rnd[a] >>> s2_shift;
            if (s3_shr[a] > SAT_HI) begin
                s3_nxt[a*W_DATA +: W_DATA] = {1'b0, {(W_DATA-1){1'b1}}};
            end else if (s3_shr[a] < SAT_LO) begin
                s3_nxt[a*W_DATA +: W_DATA] = {1'b1, {(W_DATA-1){1'b0}}};
            end else begin
                s3_nxt[a*W_DATA +: W_DATA] = s3_shr[a][W_DATA-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld <= 1'b0;
            s2_vld <= 1'b0;
            s3_vld <= 1'b0;
        end else begin
            s1_vld <= i_vld & c_last_cin;
            s2_vld <= s1_vld;
            s3_vld <= s2_vld;
        end
    end

    always_ff @(posedge clk) begin
        s1_act   <= act_eff;
        s1_shift <= shift_eff;
        s2_shift <= s1_shift;
        s3_word  <= s3_nxt;
        for (int a = 0; a < Tout; a++) begin
            s1_sum[a] <= s1_nxt[a];
            s2_val[a] <= s2_nxt[a];
        end
    end

    // Valid/ready: a word transfers on every cycle with o_ofm_vld & i_ofm_rdy; o_ofm_vld never
    // drops without a transfer, and o_ofm_data holds steady while the consumer stalls.
    logic [Tout*W_DATA-1:0] mem [FIFO_DEPTH];
    logic [AW:0]            wr_ptr, rd_ptr;
    logic [AW:0]            count;
    logic                   pop, full, push_ok, mem_nonempty, head_load;
    logic [CW-1:0]          occupancy;

    // count covers the memory plus the registered head word.
    assign pop          = o_ofm_vld & i_ofm_rdy;
    assign full         = (count == (AW+1)'(FIFO_DEPTH));
    assign push_ok      = s3_vld & (~full | pop);
    assign mem_nonempty = (wr_ptr != rd_ptr);
    assign head_load    = (~o_ofm_vld | pop) & mem_nonempty;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= s3_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_ofm_vld  <= 1'b0;
            o_ofm_data <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (head_load) begin
                o_ofm_data <= mem[rd_ptr[AW-1:0]];
                rd_ptr     <= rd_ptr + (AW+1)'(1);
                o_ofm_vld  <= 1'b1;
            end else if (pop) begin
                o_ofm_vld <= 1'b0;
            end
            count <= count + (AW+1)'(push_ok) - (AW+1)'(pop);
            if (s3_vld & full & ~pop) begin
                o_overflow <= 1'b1;
            end
        end
    end

    assign occupancy     = CW'(count) + CW'(s1_vld) + CW'(s2_vld) + CW'(s3_vld);
    assign o_almost_full = (occupancy >= CW'(FIFO_DEPTH - 1));
    assign o_busy        = s1_vld | s2_vld | s3_vld | o_psum_we | (count != '0);

endmodule

// File: tb/tb_conv_postproc.sv
// tb_conv_postproc: directed and randomized checks of conv_postproc against a behavioural model
// that works from plain integer arithmetic per lane.
`timescale 1ns/1ps
module tb_conv_postproc;
    localparam int Tout       = 4;
    localparam int W_PSUM     = 32;
    localparam int W_DATA     = 8;
    localparam int W_BIAS     = 16;
    localparam int W_SHIFT    = 5;
    localparam int FIFO_DEPTH = 4;
    localparam int WA = Tout * W_PSUM;
    localparam int WO = Tout * W_DATA;
    localparam int WB = Tout * W_BIAS;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               c_layer_start = 1'b0;
    logic [W_SHIFT-1:0] cfg_shift = '0;
    logic               cfg_act_en = 1'b0;
    logic [WB-1:0]      bm_bias_data = '0;
    logic               c_last_cin = 1'b0;
    logic               i_vld = 1'b0;
    logic [WA-1:0]      i_acc = '0;
    logic               i_ofm_rdy = 1'b0;
    logic               o_psum_we;
    logic [WA-1:0]      o_psum_data;
    logic               o_ofm_vld;
    logic [WO-1:0]      o_ofm_data;
    logic               o_almost_full;
    logic               o_overflow;
    logic               o_busy;

    int checks = 0;
    int errors = 0;

    logic [WO-1:0] exp_q[$];
    logic [WO-1:0] got_q[$];
    logic [WA-1:0] psum_exp_q[$];
    logic [WA-1:0] psum_got_q[$];

    int            m_shift = 0;
    bit            m_act = 1'b0;
    logic [WB-1:0] m_bias = '0;

    conv_postproc #(
        .Tout(Tout), .W_PSUM(W_PSUM), .W_DATA(W_DATA), .W_BIAS(W_BIAS),
        .W_SHIFT(W_SHIFT), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .c_layer_start(c_layer_start), .cfg_shift(cfg_shift),
        .cfg_act_en(cfg_act_en), .bm_bias_data(bm_bias_data), .c_last_cin(c_last_cin),
        .i_vld(i_vld), .i_acc(i_acc), .o_psum_we(o_psum_we), .o_psum_data(o_psum_data),
        .o_ofm_vld(o_ofm_vld), .o_ofm_data(o_ofm_data), .i_ofm_rdy(i_ofm_rdy),
        .o_almost_full(o_almost_full), .o_overflow(o_overflow), .o_busy(o_busy)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Record every transferred OFM word and every partial-sum write, away from the clock edge.
    always @(negedge clk) begin
        if (!rst && o_ofm_vld && i_ofm_rdy) got_q.push_back(o_ofm_data);
        if (!rst && o_psum_we) psum_got_q.push_back(o_psum_data);
    end

    // Reference model
    function automatic logic [W_DATA-1:0] ref_lane(longint acc, longint bias, int shift, bit act);
        longint v;
        v = acc + bias;
        if (act && v < 0) begin
`ifdef CONV_POSTPROC_LEAKY_EN
            v = v >>> 3;
`else
            v = 0;
`endif
        end
        if (shift > 0) v = v + (longint'(1) << (shift - 1));
        v = v >>> shift;
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return v[W_DATA-1:0];
    endfunction

    function automatic logic [WO-1:0] ref_word(logic [WA-1:0] acc, logic [WB-1:0] bias, int shift, bit act);
        logic [WO-1:0] w;
        w = '0;
        for (int a = 0; a < Tout; a++) begin
            w[a*W_DATA +: W_DATA] = ref_lane(longint'($signed(acc[a*W_PSUM +: W_PSUM])),
                                             longint'($signed(bias[a*W_BIAS +: W_BIAS])), shift, act);
        end
        return w;
    endfunction

    function automatic logic [WA-1:0] pack4(int a0, int a1, int a2, int a3);
        logic [WA-1:0] v;
        v[0*W_PSUM +: W_PSUM] = W_PSUM'(a0);
        v[1*W_PSUM +: W_PSUM] = W_PSUM'(a1);
        v[2*W_PSUM +: W_PSUM] = W_PSUM'(a2);
        v[3*W_PSUM +: W_PSUM] = W_PSUM'(a3);
        return v;
    endfunction

    function automatic logic [WA-1:0] rand_acc();
        logic [WA-1:0] v;
        for (int a = 0; a < Tout; a++) begin
            if ($urandom_range(0, 1) != 0) v[a*W_PSUM +: W_PSUM] = W_PSUM'($urandom);
            else v[a*W_PSUM +: W_PSUM] = W_PSUM'($urandom_range(0, 8000)) - W_PSUM'(4000);
        end
        return v;
    endfunction

    function automatic logic [WB-1:0] rand_bias();
        logic [WB-1:0] v;
        for (int a = 0; a < Tout; a++) v[a*W_BIAS +: W_BIAS] = W_BIAS'($urandom_range(0, 65535));
        return v;
    endfunction

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_vld = 1'b0;
        c_layer_start = 1'b0;
        c_last_cin = 1'b0;
        i_ofm_rdy = 1'b0;
        idle(2);
        rst = 1'b0;
        m_shift = 0;
        m_act = 1'b0;
        m_bias = '0;
        exp_q.delete();
        got_q.delete();
        psum_exp_q.delete();
        psum_got_q.delete();
    endtask

    // One input cycle: optional beat and optional config pulse using the current cfg_* inputs.
    task automatic drive_cycle(bit vld, bit last, logic [WA-1:0] acc, bit start);
        c_layer_start = start;
        i_vld = vld;
        c_last_cin = last;
        i_acc = acc;
        if (start) begin
            m_shift = int'(cfg_shift);
            m_act = cfg_act_en;
            m_bias = bm_bias_data;
        end
        if (vld && last) exp_q.push_back(ref_word(acc, m_bias, m_shift, m_act));
        if (vld && !last) psum_exp_q.push_back(acc);
        step();
        c_layer_start = 1'b0;
        i_vld = 1'b0;
        c_last_cin = 1'b0;
    endtask

    task automatic set_cfg(int shift, bit act, logic [WB-1:0] bias);
        cfg_shift = W_SHIFT'(shift);
        cfg_act_en = act;
        bm_bias_data = bias;
        drive_cycle(1'b0, 1'b0, '0, 1'b1);
    endtask

    task automatic wait_got(int n, int budget, output bit ok);
        int cyc = 0;
        while (got_q.size() < n && cyc < budget) begin
            step();
            cyc++;
        end
        ok = (got_q.size() >= n);
    endtask

    task automatic wait_ofm_vld(output int lat);
        lat = 0;
        while (!o_ofm_vld && lat < 12) begin
            step();
            lat++;
        end
    endtask

    // Tests
    task automatic test_reset();
        do_reset();
        checks++; if (o_psum_we !== 1'b0) begin errors++; $display("FAIL reset_psum_we got %b exp 0", o_psum_we); end
        checks++; if (o_psum_data !== '0) begin errors++; $display("FAIL reset_psum_data got %h exp 0", o_psum_data); end
        checks++; if (o_ofm_vld !== 1'b0) begin errors++; $display("FAIL reset_ofm_vld got %b exp 0", o_ofm_vld); end
        checks++; if (o_ofm_data !== '0) begin errors++; $display("FAIL reset_ofm_data got %h exp 0", o_ofm_data); end
        checks++; if (o_almost_full !== 1'b0) begin errors++; $display("FAIL reset_almost_full got %b exp 0", o_almost_full); end
        checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", o_overflow); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", o_busy); end
    endtask

    task automatic test_partial();
        logic [WA-1:0] acc;
        bit ok;
        exp_q.delete();
        got_q.delete();
        acc = pack4(100, -5, 0, 7);
        drive_cycle(1'b1, 1'b0, acc, 1'b0);
        checks++; if (o_psum_we !== 1'b1) begin errors++; $display("FAIL partial_we got %b exp 1", o_psum_we); end
        checks++; if (o_psum_data !== acc) begin errors++; $display("FAIL partial_data got %h exp %h", o_psum_data, acc); end
        checks++; if (o_ofm_vld !== 1'b0 || o_almost_full !== 1'b0) begin errors++; $display("FAIL partial_fifo_touched got vld %b af %b exp 0 0", o_ofm_vld, o_almost_full); end
        step();
        checks++; if (o_psum_we !== 1'b0) begin errors++; $display("FAIL partial_we_drop got %b exp 0", o_psum_we); end
        // Alternate paths cycle by cycle.
        set_cfg(3, 1'b1, rand_bias());
        for (int k = 0; k < 10; k++) begin
            acc = rand_acc();
            drive_cycle(1'b1, k[0], acc, 1'b0);
            if (!k[0]) begin
                checks++; if (o_psum_we !== 1'b1 || o_psum_data !== acc) begin errors++; $display("FAIL alt_psum got we %b %h exp 1 %h", o_psum_we, o_psum_data, acc); end
            end else begin
                checks++; if (o_psum_we !== 1'b0) begin errors++; $display("FAIL alt_final_we got %b exp 0", o_psum_we); end
            end
        end
        i_ofm_rdy = 1'b1;
        wait_got(exp_q.size(), 40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL alt_drain_timeout got %0d exp %0d words", got_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            checks++; if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL alt_word[%0d] got %h exp %h", k, got_q[k], exp_q[k]); end
        end
        i_ofm_rdy = 1'b0;
        idle(2);
    endtask

    task automatic test_requant();
        int lat;
        logic [WO-1:0] head;
        exp_q.delete();
        got_q.delete();
        set_cfg(4, 1'b0, '0);
        drive_cycle(1'b1, 1'b1, pack4(24, 23, -24, 2047), 1'b0);
        wait_ofm_vld(lat);
        head = exp_q[0];
        checks++; if (lat != 4) begin errors++; $display("FAIL requant_latency got %0d exp 4", lat); end
        checks++; if (o_ofm_data !== 32'h7FFF_0102) begin errors++; $display("FAIL requant_const got %h exp 7fff0102", o_ofm_data); end
        checks++; if (o_ofm_data !== head) begin errors++; $display("FAIL requant_model got %h exp %h", o_ofm_data, head); end
        i_ofm_rdy = 1'b1;
        step();
        i_ofm_rdy = 1'b0;
        checks++; if (o_ofm_vld !== 1'b0 || o_busy !== 1'b0) begin errors++; $display("FAIL requant_pop got vld %b busy %b exp 0 0", o_ofm_vld, o_busy); end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_activation();
        int lat;
        logic [WO-1:0] head;
        logic [WO-1:0] want;
`ifdef CONV_POSTPROC_LEAKY_EN
        want = 32'h800F_00F6;
`else
        want = 32'h000F_0000;
`endif
        exp_q.delete();
        got_q.delete();
        set_cfg(0, 1'b1, 64'h000A_000A_000A_000A);
        drive_cycle(1'b1, 1'b1, pack4(-90, -10, 5, -2000), 1'b0);
        wait_ofm_vld(lat);
        head = exp_q[0];
        checks++; if (o_ofm_data !== want) begin errors++; $display("FAIL act_const got %h exp %h", o_ofm_data, want); end
        checks++; if (o_ofm_data !== head) begin errors++; $display("FAIL act_model got %h exp %h", o_ofm_data, head); end
        i_ofm_rdy = 1'b1;
        step();
        i_ofm_rdy = 1'b0;
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_random();
        bit ok;
        exp_q.delete();
        got_q.delete();
        psum_exp_q.delete();
        psum_got_q.delete();
        for (int t = 0; t < 400; t++) begin
            int kind;
            bit start;
            kind = $urandom_range(0, 3);
            start = ($urandom_range(0, 15) == 0);
            i_ofm_rdy = ($urandom_range(0, 3) != 0);
            if (start) begin
                cfg_shift = W_SHIFT'($urandom_range(0, 31));
                cfg_act_en = 1'($urandom_range(0, 1));
                bm_bias_data = rand_bias();
            end
            if (kind == 1) drive_cycle(1'b1, 1'b0, rand_acc(), start);
            else if (kind >= 2 && !o_almost_full) drive_cycle(1'b1, 1'b1, rand_acc(), start);
            else drive_cycle(1'b0, 1'b0, '0, start);
        end
        i_ofm_rdy = 1'b1;
        wait_got(exp_q.size(), 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rand_drain_timeout got %0d exp %0d words", got_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            checks++; if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL rand_word[%0d] got %h exp %h", k, got_q[k], exp_q[k]); end
        end
        checks++; if (psum_got_q.size() != psum_exp_q.size()) begin errors++; $display("FAIL rand_psum_count got %0d exp %0d", psum_got_q.size(), psum_exp_q.size()); end
        for (int k = 0; k < psum_exp_q.size() && k < psum_got_q.size(); k++) begin
            checks++; if (psum_got_q[k] !== psum_exp_q[k]) begin errors++; $display("FAIL rand_psum[%0d] got %h exp %h", k, psum_got_q[k], psum_exp_q[k]); end
        end
        checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL rand_overflow got %b exp 0", o_overflow); end
        i_ofm_rdy = 1'b0;
        idle(2);
    endtask

    task automatic test_backpressure();
        bit ok;
        exp_q.delete();
        got_q.delete();
        set_cfg($urandom_range(0, 31), 1'($urandom_range(0, 1)), rand_bias());
        i_ofm_rdy = 1'b0;
        for (int k = 0; k < 6; k++) drive_cycle(1'b1, 1'b1, rand_acc(), 1'b0);
        // Only the first FIFO_DEPTH words fit; the last two are dropped.
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        idle(6);
        checks++; if (o_overflow !== 1'b1) begin errors++; $display("FAIL bp_overflow got %b exp 1", o_overflow); end
        checks++; if (o_ofm_vld !== 1'b1 || o_almost_full !== 1'b1) begin errors++; $display("FAIL bp_full got vld %b af %b exp 1 1", o_ofm_vld, o_almost_full); end
        i_ofm_rdy = 1'b1;
        wait_got(4, 20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_drain_timeout got %0d exp 4 words", got_q.size()); end
        for (int k = 0; k < 4 && k < got_q.size(); k++) begin
            checks++; if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL bp_word[%0d] got %h exp %h", k, got_q[k], exp_q[k]); end
        end
        idle(3);
        checks++; if (got_q.size() != 4 || o_busy !== 1'b0) begin errors++; $display("FAIL bp_extra got %0d words busy %b exp 4 words busy 0", got_q.size(), o_busy); end
        checks++; if (o_overflow !== 1'b1) begin errors++; $display("FAIL bp_sticky got %b exp 1", o_overflow); end
        i_ofm_rdy = 1'b0;
    endtask

    task automatic test_reset_midstream();
        i_ofm_rdy = 1'b0;
        for (int k = 0; k < 3; k++) drive_cycle(1'b1, 1'b1, rand_acc(), 1'b0);
        idle(4);
        drive_cycle(1'b1, 1'b1, rand_acc(), 1'b0);
        drive_cycle(1'b1, 1'b1, rand_acc(), 1'b0);
        checks++; if (o_ofm_vld !== 1'b1 || o_busy !== 1'b1) begin errors++; $display("FAIL mid_pre got vld %b busy %b exp 1 1", o_ofm_vld, o_busy); end
        rst = 1'b1;
        step();
        checks++; if (o_ofm_vld !== 1'b0) begin errors++; $display("FAIL mid_vld got %b exp 0", o_ofm_vld); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b exp 0", o_busy); end
        checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL mid_overflow got %b exp 0", o_overflow); end
        checks++; if (o_almost_full !== 1'b0) begin errors++; $display("FAIL mid_almost_full got %b exp 0", o_almost_full); end
        rst = 1'b0;
        m_shift = 0;
        m_act = 1'b0;
        m_bias = '0;
        exp_q.delete();
        got_q.delete();
        i_ofm_rdy = 1'b1;
        idle(8);
        checks++; if (got_q.size() != 0 || o_busy !== 1'b0) begin errors++; $display("FAIL mid_leak got %0d words busy %b exp 0 0", got_q.size(), o_busy); end
        i_ofm_rdy = 1'b0;
    endtask

    task automatic test_push_pop_full();
        bit ok;
        exp_q.delete();
        got_q.delete();
        set_cfg($urandom_range(0, 31), 1'($urandom_range(0, 1)), rand_bias());
        i_ofm_rdy = 1'b0;
        for (int k = 0; k < 4; k++) drive_cycle(1'b1, 1'b1, rand_acc(), 1'b0);
        idle(6);
        checks++; if (o_ofm_vld !== 1'b1 || o_almost_full !== 1'b1) begin errors++; $display("FAIL ppf_full got vld %b af %b exp 1 1", o_ofm_vld, o_almost_full); end
        drive_cycle(1'b1, 1'b1, rand_acc(), 1'b0);
        idle(2);
        // The fifth beat reaches the FIFO on the next edge; pop on exactly that edge.
        i_ofm_rdy = 1'b1;
        step();
        i_ofm_rdy = 1'b0;
        checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL ppf_overflow got %b exp 0", o_overflow); end
        checks++; if (o_ofm_vld !== 1'b1 || o_almost_full !== 1'b1 || got_q.size() != 1) begin errors++; $display("FAIL ppf_state got vld %b af %b words %0d exp 1 1 1", o_ofm_vld, o_almost_full, got_q.size()); end
        i_ofm_rdy = 1'b1;
        wait_got(5, 20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ppf_drain_timeout got %0d exp 5 words", got_q.size()); end
        for (int k = 0; k < 5 && k < got_q.size(); k++) begin
            checks++; if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL ppf_word[%0d] got %h exp %h", k, got_q[k], exp_q[k]); end
        end
        idle(2);
        checks++; if (o_busy !== 1'b0 || o_overflow !== 1'b0) begin errors++; $display("FAIL ppf_end got busy %b ovf %b exp 0 0", o_busy, o_overflow); end
        i_ofm_rdy = 1'b0;
    endtask

    // Sequence and final report
    initial begin
        test_reset();
        test_partial();
        test_requant();
        test_activation();
        test_random();
        test_backpressure();
        test_reset_midstream();
        test_push_pop_full();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_postproc.md
# conv_postproc

Output stage directly downstream of the convolution PE array. Takes the Tout per-lane 32-bit accumulations the PE emits each valid cycle. On intermediate input-channel tiles it forwards them unchanged to the partial-sum buffer. On the last input-channel tile it adds bias, applies activation, requantizes to 8 bits, packs the Tout bytes into one OFM word, and queues the word in a small FIFO for the output-buffer writer.

## Interface
- Tout, 4, output channels per PE cycle (lanes)
- W_PSUM, 32, accumulation width per lane
- W_DATA, 8, OFM element width
- W_BIAS, 16, bias width per lane (signed)
- W_SHIFT, 5, requantization shift-amount width
- FIFO_DEPTH, 4, OFM queue depth (power of two, ≥4)
- clk  in  1  clock
- rst  in  1  reset, synchronous and active-high
- c_layer_start  in  1  one-cycle pulse; latches cfg_shift, cfg_act_en and bm_bias_data
- cfg_shift  in  W_SHIFT  requantization right shift, 0..31
- cfg_act_en  in  1  activation enable
- bm_bias_data  in  Tout*W_BIAS  per-lane signed bias, lane a at [a*W_BIAS+:W_BIAS]
- c_last_cin  in  1  qualifies i_vld: 1 = final input-channel tile, 0 = partial
- i_vld  in  1  all Tout lanes valid
- i_acc  in  Tout*W_PSUM  signed lane accumulations, lane a at [a*W_PSUM+:W_PSUM]
- o_psum_we  out  1  partial-sum write strobe
- o_psum_data  out  Tout*W_PSUM  partial sums, unchanged
- o_ofm_vld  out  1  FIFO head valid
- o_ofm_data  out  Tout*W_DATA  packed OFM word, lane a at [a*W_DATA+:W_DATA]
- i_ofm_rdy  in  1  consumer accepts the head word when o_ofm_vld & i_ofm_rdy
- o_almost_full  out  1  upstream must stop issuing final-tile i_vld
- o_overflow  out  1  sticky; a result was dropped
- o_busy  out  1  pipeline or FIFO non-empty

## Operation
- Config registers reset to 0 and load only on c_layer_start. A pulse coincident with i_vld: that beat uses the new values.
- Partial path, i_vld & !c_last_cin: i_acc is registered. The next cycle o_psum_we=1 and o_psum_data holds the registered i_acc. No arithmetic.
- Final path, i_vld & c_last_cin: 3-stage pipeline with per-lane valid shared by all lanes.
  - S1: sum = sext(i_acc) + sext(bias), 33-bit signed.
  - S2: activation. cfg_act_en=0 passes through. cfg_act_en=1 with a negative value applies the activation per Configuration. Non-negative values pass through.
  - S3: if cfg_shift>0, add 1<<(cfg_shift-1), then arithmetic right shift by cfg_shift (round half up). Saturate to [-128,127]. Take the low 8 bits.
  - S3 output is written to the FIFO tail.
- FIFO: circular buffer, FIFO_DEPTH entries, binary pointers with one extra wrap bit.
  - o_ofm_vld = !empty; o_ofm_data = head entry, registered.
  - Pop on o_ofm_vld & i_ofm_rdy.
  - Push and pop in the same cycle are both legal when full or empty (empty: push only; full: pop frees the slot first, so the push succeeds).
- o_almost_full = (count + beats in S1..S3) ≥ FIFO_DEPTH-1.
- Push while full with no pop: the word is dropped, o_overflow is set, and count is unchanged. o_overflow clears only on rst.
- o_busy = any stage valid | psum register valid | !empty.

## Timing
- Reset values: every output is 0, pointers and count are 0, config is 0, and all stage valids are 0.
- rst mid-operation: in-flight beats and FIFO contents are discarded the next cycle. No partial word is emitted.
- Partial-path latency: 1 cycle, i_vld edge to o_psum_we.
- Final-path latency: 3 cycles into the FIFO. With an empty FIFO, o_ofm_vld rises 4 cycles after i_vld.
- Throughput: one beat per cycle on either path. The paths may alternate cycle by cycle, and each beat's c_last_cin selects its path independently.
- o_almost_full is combinational from registered state. Upstream samples it before issuing.

## Configuration
- CONV_POSTPROC_LEAKY_EN defined: the activation is leaky ReLU, where a negative x becomes x>>>3 (arithmetic shift, slope 1/8).
- CONV_POSTPROC_LEAKY_EN undefined: the activation is plain ReLU, where a negative x becomes 0. Latency is unchanged.

## Test plan
- Partial path: i_acc lanes {100,-5,0,7}, c_last_cin=0 -> next cycle o_psum_we=1, data identical; FIFO untouched.
- Requant and rounding: bias 0, shift 4, act off, acc {24,23,-24,2047} -> bytes {2,1,-1 (0xFF),127}, o_ofm_vld at cycle +4.
- Activation: bias 10, shift 0, act on, acc {-90,-10,5,-2000} -> leaky build {-10,0,15,-128}; ReLU build {0,0,15,0}.
- Back-pressure: i_ofm_rdy=0, 6 consecutive final beats with o_almost_full ignored -> 4 words held, o_overflow=1; release rdy -> the first 4 words drain in order.
- Simultaneous push/pop at full: FIFO full, rdy=1, beat arriving -> count stays 4, no overflow, FIFO order preserved.
- Reset mid-stream: assert rst with 2 beats in flight and 3 queued -> next cycle o_ofm_vld=0, o_busy=0, o_overflow=0.
